// File: rtl/scan_pkg.sv
// Shared types and constants for the bit-serial pattern scanner.
package scan_pkg;

   // Controller phases: waiting, consuming bits, publishing results.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ctrl_state_t;

   // Detector progress: how much of the pattern prefix has been seen.
   typedef enum logic [1:0] {
      D_S0   = 2'd0,  // nothing useful
      D_S1   = 2'd1,  // "1"
      D_S11  = 2'd2,  // "11"
      D_S110 = 2'd3   // "110"
   } det_state_t;

   // Sequence being searched for, first bit received is PATTERN[3].
   localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_det_1101.sv
// Overlapping Mealy detector for 1101; hit is asserted combinationally on
// the cycle that presents the final '1' while en is high.
module seq_det_1101
   import scan_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic in,
   output logic hit
);

   det_state_t st, st_nx;

   // State register: clr restarts the search, en advances it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      st <= D_S0;
      else if (clr)  st <= D_S0;
      else if (en)   st <= st_nx;
   end

   // Transitions; after a hit the trailing '1' is the start of the next match.
   always_comb begin
      st_nx = st;
      hit   = 1'b0;
      case (st)
         D_S0:   st_nx = (in == PATTERN[3]) ? D_S1   : D_S0;
         D_S1:   st_nx = (in == PATTERN[2]) ? D_S11  : D_S0;
         D_S11:  st_nx = (in == PATTERN[1]) ? D_S110 : D_S11;
         D_S110: begin
            if (in == PATTERN[0]) begin
               hit   = en;
               st_nx = D_S1;
            end else begin
               st_nx = D_S0;
            end
         end
         default: st_nx = D_S0;
      endcase
   end

endmodule

// File: rtl/scan_ctrl.sv
// Scans a captured word MSB-first through the 1101 detector, counting
// overlapping matches and noting where the first one ends.
module scan_ctrl
   import scan_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CW    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    match_count,
   output logic             found,
   output logic [CW-1:0]    first_pos
);

   ctrl_state_t      state, state_nx;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    bitcnt, wcount, wfirst;
   logic             accept, consume, last, hit;

   assign last = (bitcnt == CW'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next state; abort beats the final bit, and is ignored outside SHIFT.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (abort) state_nx = IDLE;
                  else if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Control strobes derived from the current state.
   always_comb begin
      busy    = (state != IDLE);
      accept  = (state == IDLE) && start;
      consume = (state == SHIFT);
   end

   seq_det_1101 u_det (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .en  (consume),
      .in  (sreg[WIDTH-1]),
      .hit (hit)
   );

   // Shift register and working results; a stale working set after abort
   // is harmless because the next accept clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg   <= '0;
         bitcnt <= '0;
         wcount <= '0;
         wfirst <= '0;
      end else if (accept) begin
         sreg   <= data;
         bitcnt <= '0;
         wcount <= '0;
         wfirst <= '0;
      end else if (consume) begin
         sreg   <= {sreg[WIDTH-2:0], 1'b0};
         bitcnt <= bitcnt + CW'(1);
         if (hit) begin
            wcount <= wcount + CW'(1);
            if (wcount == '0) wfirst <= bitcnt;
         end
      end
   end

   // Published results: loaded only when leaving DONE, held otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done        <= 1'b0;
         match_count <= '0;
         found       <= 1'b0;
         first_pos   <= '0;
      end else begin
         done <= (state == DONE);
         if (state == DONE) begin
            match_count <= wcount;
            found       <= (wcount != '0);
            first_pos   <= wfirst;
         end
      end
   end

endmodule

// File: tb/tb_scan_ctrl.sv
// Randomized and directed bench with a scoreboard for scan_ctrl (WIDTH=16).
module tb_scan_ctrl;

   localparam int WIDTH = 16;
   localparam int CW    = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] data = '0;
   logic             abort = 1'b0;
   logic             busy, done, found;
   logic [CW-1:0]    match_count, first_pos;

   scan_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .data        (data),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .match_count (match_count),
      .found       (found),
      .first_pos   (first_pos)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      int first;
      int fnd;
      int t;
   } res_t;

   res_t sb[$];
   res_t m_out;
   int   ncmp = 0;
   int   nerr = 0;
   int   tnow = 0;      // edges seen by the driver
   bit   m_busy = 0;
   int   m_acc = 0;
   logic [WIDTH-1:0] m_data = '0;

   task automatic chk(input string name, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, tnow);
      end
   endtask

   // Reference: slide a 4-bit window along the word, index 0 = MSB.
   function automatic res_t ref_scan(input logic [WIDTH-1:0] d);
      res_t r;
      logic [3:0] w;
      r.cnt = 0; r.first = 0; r.t = 0;
      for (int i = 3; i < WIDTH; i++) begin
         w = {d[WIDTH-1-(i-3)], d[WIDTH-1-(i-2)], d[WIDTH-1-(i-1)], d[WIDTH-1-i]};
         if (w == 4'b1101) begin
            if (r.cnt == 0) r.first = i;
            r.cnt++;
         end
      end
      r.fnd = (r.cnt != 0);
      return r;
   endfunction

   // One clock: drive, advance, update the transaction-level model, check.
   task automatic step(input logic s, input logic [WIDTH-1:0] d, input logic a);
      res_t r;
      start = s; data = d; abort = a;
      @(posedge clk);
      tnow++;
      if (rst) begin
         if (!m_busy) begin
            if (s) begin m_busy = 1; m_acc = tnow; m_data = d; end
         end else if (tnow - m_acc <= WIDTH) begin
            if (a) m_busy = 0;
         end else begin
            r = ref_scan(m_data);
            r.t = tnow;
            sb.push_back(r);
            m_out = r;
            m_busy = 0;
         end
      end
      #1;
      chk("busy", busy, m_busy);
      chk("hold_count", match_count, m_out.cnt);
      chk("hold_found", found, m_out.fnd);
      chk("hold_first", first_pos, m_out.first);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_count"}, match_count, 0);
      chk({tag, "_found"}, found, 0);
      chk({tag, "_first"}, first_pos, 0);
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      res_t e;
      if (rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("done_time", tnow, e.t);
            chk("done_count", match_count, e.cnt);
            chk("done_found", found, e.fnd);
            chk("done_first", first_pos, e.first);
         end
      end
   end

   initial begin
      m_out = '{0, 0, 0, 0};
      #1 chk_zero("reset");
      idle(2);
      rst = 1'b1;

      // Single-match, overlap and no-match words.
      step(1'b1, 16'hD000, 1'b0); idle(20);
      chk("d000_count", match_count, 1);
      chk("d000_first", first_pos, 3);
      step(1'b1, 16'hDB68, 1'b0); idle(20);
      chk("db68_count", match_count, 4);
      chk("db68_first", first_pos, 3);
      step(1'b1, 16'h0000, 1'b0); idle(20);
      chk("0000_found", found, 0);
      step(1'b1, 16'hFFFF, 1'b0); idle(20);
      chk("ffff_count", match_count, 0);

      // Restart ignored mid-scan, then abort: outputs keep D000 results.
      step(1'b1, 16'hD000, 1'b0); idle(20);
      step(1'b1, 16'hDB68, 1'b0);
      idle(3);
      step(1'b1, 16'hFFFF, 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      chk("abort_busy", busy, 0);
      idle(20);
      chk("abort_keep", match_count, 1);

      // Abort on the final bit wins; abort in DONE is ignored.
      step(1'b1, 16'hDB68, 1'b0); idle(15); step(1'b0, '0, 1'b1); idle(4);
      step(1'b1, 16'hDB68, 1'b0); idle(16); step(1'b0, '0, 1'b1); idle(4);
      chk("abort_done_count", match_count, 4);

      // Reset in the middle of a scan.
      step(1'b1, 16'hDB68, 1'b0);
      idle(8);
      #2 rst = 1'b0;
      #1;
      chk_zero("midreset");
      m_busy = 0;
      m_out = '{0, 0, 0, 0};
      idle(2);
      rst = 1'b1;
      step(1'b1, 16'hD000, 1'b0); idle(20);
      chk("post_reset_count", match_count, 1);

      // start held high: back-to-back scans.
      for (int i = 0; i < 40; i++) step(1'b1, 16'hD000, 1'b0);
      idle(25);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         logic [WIDTH-1:0] d;
         d = WIDTH'($urandom);
         if ($urandom_range(0, 2) == 0) d[15:8] = 8'hDB;
         step($urandom_range(0, 3) == 0, d, $urandom_range(0, 15) == 0);
      end
      idle(25);

      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
